// File: rtl/ttl_cen_sequencer_if.sv
// ttl_cen_sequencer_if
//   Control/status bundle between a board model and the Cen sequencer.
//   master : board side, drives run enables, per-channel Div/Phase and the
//            pause/step requests; observes the generated enables.
//   slave  : sequencer side.
//   Signals:
//     Enable      [CHANNELS]        per-channel run enable
//     Div         [CHANNELS*DIV_W]  per-channel half-period minus 1
//     Phase       [CHANNELS*DIV_W]  per-channel counter preload
//     Pause_req                     level request to freeze at a safe point
//     Step_req                      one-cycle pulse, one channel-0 period
//     Cen         [CHANNELS]        generated clock enables
//     Fall_strobe [CHANNELS]        one-cycle pulse on the first low cycle
//     Pause_ack                     high while frozen
interface ttl_cen_sequencer_if #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DIV_W    = 8
);
   logic [CHANNELS-1:0]       Enable;
   logic [CHANNELS*DIV_W-1:0] Div;
   logic [CHANNELS*DIV_W-1:0] Phase;
   logic                      Pause_req;
   logic                      Step_req;
   logic [CHANNELS-1:0]       Cen;
   logic [CHANNELS-1:0]       Fall_strobe;
   logic                      Pause_ack;

   modport master (
      output Enable, Div, Phase, Pause_req, Step_req,
      input  Cen, Fall_strobe, Pause_ack
   );

   modport slave (
      input  Enable, Div, Phase, Pause_req, Step_req,
      output Cen, Fall_strobe, Pause_ack
   );
endinterface

// File: rtl/ttl_cen_sequencer.sv
// ttl_cen_sequencer
//   Generates phased, programmable 50%-duty clock enables for synchronous
//   TTL models and provides a pause / drain / single-step handshake that
//   freezes every channel with Cen high.
//   Ports:
//     Clk      system clock, rising edge
//     Reset_n  synchronous active-low reset
//     seq      ttl_cen_sequencer_if.slave (Enable, Div, Phase, Pause_req,
//              Step_req in; Cen, Fall_strobe, Pause_ack out, all registered)
module ttl_cen_sequencer #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DIV_W    = 8
) (
   input logic                   Clk,
   input logic                   Reset_n,
   ttl_cen_sequencer_if.slave    seq
);

   typedef enum logic [1:0] {RUN, DRAIN, PAUSED, STEP} state_t;

   state_t              state_q, state_nxt;
   logic [CHANNELS-1:0] cen_q, cen_nxt;
   logic [CHANNELS-1:0] fall_q, fall_nxt;
   logic [CHANNELS-1:0] run_mask;
   logic                ack_q, ack_nxt;
   logic                step_fell_q, step_fell_nxt;

   // ---------------- state register ----------------
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q     <= RUN;
         cen_q       <= '1;
         fall_q      <= '0;
         ack_q       <= 1'b0;
         step_fell_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         cen_q       <= cen_nxt;
         fall_q      <= fall_nxt;
         ack_q       <= ack_nxt;
         step_fell_q <= step_fell_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         RUN:    if (seq.Pause_req) state_nxt = DRAIN;
         DRAIN:  if (!seq.Pause_req) state_nxt = RUN;
                 else if (&cen_q)    state_nxt = PAUSED;
         // Resume has priority over a simultaneous step request.
         PAUSED: if (!seq.Pause_req)    state_nxt = RUN;
                 else if (seq.Step_req) state_nxt = STEP;
         // Step ends once channel 0 has fallen and is high again; a
         // disabled channel 0 can never complete a period.
         STEP:   if (!seq.Enable[0] || (step_fell_q && cen_q[0]))
                    state_nxt = DRAIN;
         default: state_nxt = RUN;
      endcase
   end

   // ---------------- output / control logic ----------------
   always_comb begin
      run_mask = '0;
      case (state_q)
         RUN, STEP: run_mask = '1;
         DRAIN:     run_mask = ~cen_q;   // only low channels finish their half-period
         default:   run_mask = '0;
      endcase
      fall_nxt      = cen_q & ~cen_nxt;
      ack_nxt       = (state_nxt == PAUSED);
      step_fell_nxt = (state_nxt == STEP) &&
                      (step_fell_q || (cen_q[0] && !cen_nxt[0]));
   end

   // ---------------- per-channel counters ----------------
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [DIV_W-1:0] dv, ph, pre;
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic             cen_d;

      assign dv  = seq.Div[g*DIV_W +: DIV_W];
      assign ph  = seq.Phase[g*DIV_W +: DIV_W];
      assign pre = (ph < dv) ? ph : dv;

      always_comb begin
         cnt_d = cnt_q;
         cen_d = cen_q[g];
         if (!seq.Enable[g]) begin
            cnt_d = pre;
            cen_d = 1'b1;
         end else if (run_mask[g]) begin
            // >= lets a shrunken Div wrap on the very next cycle.
            if (cnt_q >= dv) begin
               cnt_d = '0;
               cen_d = ~cen_q[g];
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
      end

      always_ff @(posedge Clk) begin
         if (!Reset_n) cnt_q <= pre;
         else          cnt_q <= cnt_d;
      end

      assign cen_nxt[g] = cen_d;
   end

   assign seq.Cen         = cen_q;
   assign seq.Fall_strobe = fall_q;
   assign seq.Pause_ack   = ack_q;

endmodule

// File: tb/tb_ttl_cen_sequencer.sv
module tb_ttl_cen_sequencer;
   localparam int CH = 4;
   localparam int DW = 8;

   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   ttl_cen_sequencer_if #(.CHANNELS(CH), .DIV_W(DW)) bus ();

   ttl_cen_sequencer #(.CHANNELS(CH), .DIV_W(DW)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .seq     (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: each channel tracks cycles remaining before its next
   // toggle and its current level; the sequencer mode is a plain string.
   int    m_rem [CH];
   int    m_div [CH];
   bit    m_lvl [CH];
   bit    m_fs  [CH];
   bit    m_ack;
   bit    m_seen;
   string m_mode = "RUN";

   int obs_fall [CH];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int getdiv(int i);
      logic [DW-1:0] v;
      v = bus.Div[i*DW +: DW];
      return int'(v);
   endfunction

   function automatic int getpre(int i);
      logic [DW-1:0] v;
      int d;
      v = bus.Phase[i*DW +: DW];
      d = getdiv(i);
      return (int'(v) < d) ? int'(v) : d;
   endfunction

   task automatic model_step();
      string nm;
      bit    all_hi, nl, fell0, moving;
      int    d;
      if (!Reset_n) begin
         for (int i = 0; i < CH; i++) begin
            m_div[i] = getdiv(i);
            m_rem[i] = m_div[i] - getpre(i);
            m_lvl[i] = 1'b1;
            m_fs[i]  = 1'b0;
         end
         m_mode = "RUN"; m_ack = 1'b0; m_seen = 1'b0;
         return;
      end
      all_hi = 1'b1;
      for (int i = 0; i < CH; i++) all_hi &= m_lvl[i];
      nm = m_mode;
      if (m_mode == "RUN") begin
         if (bus.Pause_req) nm = "DRAIN";
      end else if (m_mode == "DRAIN") begin
         if (!bus.Pause_req) nm = "RUN";
         else if (all_hi)    nm = "PAUSED";
      end else if (m_mode == "PAUSED") begin
         if (!bus.Pause_req)   nm = "RUN";
         else if (bus.Step_req) nm = "STEP";
      end else begin
         if (!bus.Enable[0] || (m_seen && m_lvl[0])) nm = "DRAIN";
      end
      fell0 = 1'b0;
      for (int i = 0; i < CH; i++) begin
         d = getdiv(i);
         m_rem[i] += d - m_div[i];
         m_div[i] = d;
         moving = (m_mode == "RUN") || (m_mode == "STEP") ||
                  ((m_mode == "DRAIN") && !m_lvl[i]);
         nl = m_lvl[i];
         if (!bus.Enable[i]) begin
            m_rem[i] = d - getpre(i);
            nl = 1'b1;
         end else if (moving) begin
            if (m_rem[i] <= 0) begin nl = !nl; m_rem[i] = d; end
            else m_rem[i]--;
         end
         m_fs[i] = m_lvl[i] && !nl;
         if (i == 0 && m_mode == "STEP" && m_fs[0]) fell0 = 1'b1;
         m_lvl[i] = nl;
      end
      m_seen = (nm == "STEP") && (m_seen || fell0);
      m_mode = nm;
      m_ack  = (nm == "PAUSED");
   endtask

   task automatic cyc();
      logic [CH-1:0] ec, ef;
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      for (int i = 0; i < CH; i++) begin
         ec[i] = m_lvl[i];
         ef[i] = m_fs[i];
         if (bus.Fall_strobe[i]) obs_fall[i]++;
      end
      chk("cen", 32'(bus.Cen), 32'(ec));
      chk("fall", 32'(bus.Fall_strobe), 32'(ef));
      chk("ack", 32'(bus.Pause_ack), 32'(m_ack));
   endtask

   task automatic clr_obs();
      for (int i = 0; i < CH; i++) obs_fall[i] = 0;
   endtask

   task automatic wait_ack(string tag);
      for (int k = 0; k < 80 && !bus.Pause_ack; k++) cyc();
      chk(tag, 32'(bus.Pause_ack), 32'd1);
   endtask

   initial begin
      int n, lowcnt, f0, f1, c;
      Reset_n       = 1'b0;
      bus.Enable    = 4'hF;
      bus.Div       = {8'd7, 8'd0, 8'd1, 8'd3};
      bus.Phase     = '0;
      bus.Pause_req = 1'b0;
      bus.Step_req  = 1'b0;
      repeat (2) cyc();
      chk("rst_cen", 32'(bus.Cen), 32'hF);
      chk("rst_fall", 32'(bus.Fall_strobe), 32'h0);
      chk("rst_ack", 32'(bus.Pause_ack), 32'h0);

      // Periods 8 / 4 / 2 / 16 over 32 cycles
      Reset_n = 1'b1; clr_obs();
      repeat (32) cyc();
      chk("falls_ch0", 32'(obs_fall[0]), 32'd4);
      chk("falls_ch1", 32'(obs_fall[1]), 32'd8);
      chk("falls_ch2", 32'(obs_fall[2]), 32'd16);
      chk("falls_ch3", 32'(obs_fall[3]), 32'd2);

      // Phase skew
      Reset_n   = 1'b0;
      bus.Div   = {8'd7, 8'd0, 8'd3, 8'd3};
      bus.Phase = {8'd0, 8'd0, 8'd0, 8'd2};
      cyc();
      Reset_n = 1'b1; f0 = -1; f1 = -1;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (bus.Fall_strobe[0] && f0 < 0) f0 = k;
         if (bus.Fall_strobe[1] && f1 < 0) f1 = k;
      end
      chk("first_fall_ch0", 32'(f0), 32'd2);
      chk("skew", 32'(f1 - f0), 32'd2);
      repeat (20) cyc();

      // Drain from cnt0=1, Cen0=0 with only channel 0 running
      bus.Enable = 4'b0001;
      bus.Phase  = '0;
      bus.Div    = {8'd7, 8'd0, 8'd1, 8'd3};
      cyc();
      for (int k = 0; k < 40 && !(m_lvl[0] == 1'b0 && m_rem[0] == 2); k++) cyc();
      bus.Pause_req = 1'b1;
      n = 0;
      do begin cyc(); n++; end while (!bus.Pause_ack && n < 40);
      chk("pause_latency", 32'(n), 32'd4);
      clr_obs();
      repeat (100) cyc();
      chk("frozen_falls", 32'(obs_fall[0] + obs_fall[1] + obs_fall[2] + obs_fall[3]), 32'd0);
      chk("frozen_cen", 32'(bus.Cen), 32'hF);

      // Single step
      bus.Step_req = 1'b1; cyc(); bus.Step_req = 1'b0;
      chk("step_ack_low", 32'(bus.Pause_ack), 32'd0);
      clr_obs(); lowcnt = 0; n = 0;
      while (!bus.Pause_ack && n < 60) begin
         cyc(); n++;
         if (!bus.Cen[0]) lowcnt++;
      end
      chk("step_reack", 32'(bus.Pause_ack), 32'd1);
      chk("step_falls", 32'(obs_fall[0]), 32'd1);
      chk("step_low", 32'(lowcnt), 32'd4);
      clr_obs();
      repeat (20) cyc();
      chk("post_step_falls", 32'(obs_fall[0]), 32'd0);

      // Resume together with a step pulse: resume wins
      bus.Enable = 4'hF;
      bus.Pause_req = 1'b0; bus.Step_req = 1'b1; cyc(); bus.Step_req = 1'b0;
      repeat (15) cyc();

      // Drop the request while draining
      bus.Pause_req = 1'b1; repeat (2) cyc();
      bus.Pause_req = 1'b0; repeat (20) cyc();

      // Reset during STEP
      bus.Pause_req = 1'b1;
      wait_ack("ack_before_step");
      bus.Step_req = 1'b1; cyc(); bus.Step_req = 1'b0;
      repeat (2) cyc();
      Reset_n = 1'b0; bus.Pause_req = 1'b0; cyc();
      chk("step_rst_cen", 32'(bus.Cen), 32'hF);
      chk("step_rst_ack", 32'(bus.Pause_ack), 32'd0);
      Reset_n = 1'b1;

      // Disable channel 2 mid-run
      repeat (5) cyc();
      bus.Enable[2] = 1'b0; cyc();
      chk("dis_cen2", 32'(bus.Cen[2]), 32'd1);
      clr_obs(); repeat (10) cyc();
      chk("dis_falls2", 32'(obs_fall[2]), 32'd0);
      chk("dis_hold2", 32'(bus.Cen[2]), 32'd1);
      bus.Enable[2] = 1'b1;

      // Randomized traffic against the model
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 19) == 0) bus.Pause_req = ~bus.Pause_req;
         bus.Step_req = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 49) == 0) begin
            c = $urandom_range(0, CH - 1);
            bus.Enable[c] = ~bus.Enable[c];
         end
         if ($urandom_range(0, 39) == 0) begin
            c = $urandom_range(0, CH - 1);
            bus.Div[c*DW +: DW] = DW'($urandom_range(0, 5));
         end
         if ($urandom_range(0, 59) == 0) begin
            c = $urandom_range(0, CH - 1);
            bus.Phase[c*DW +: DW] = DW'($urandom_range(0, 6));
         end
         Reset_n = ($urandom_range(0, 199) != 0);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ttl_cen_sequencer.md
Name: ttl_cen_sequencer

Overview:
- Generates phased, programmable clock-enable waveforms (Cen) that drive the synchronous TTL flip-flop and counter models. Those models act on the falling edge of Cen, sampled on Clk.
- Provides a pause/drain/single-step handshake so the system can freeze all TTL logic at a safe point (every Cen high, no falling edge pending), e.g. for save-state or debug.
- Sits between the master clock domain and all Cen-consuming TTL blocks of a board model.

Parameters:
- CHANNELS, 4, number of independent Cen outputs.
- DIV_W, 8, width of each per-channel half-period and phase field.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- Enable  input  CHANNELS  per-channel run enable.
- Div  input  CHANNELS*DIV_W  per-channel half-period minus 1; channel i uses Div[i*DIV_W +: DIV_W].
- Phase  input  CHANNELS*DIV_W  per-channel counter preload applied at reset and while the channel is disabled.
- Pause_req  input  1  level request to freeze.
- Step_req  input  1  single-cycle pulse; requests one channel-0 period while paused.
- Cen  output  CHANNELS  generated clock enables.
- Fall_strobe  output  CHANNELS  one-Clk pulse in the first cycle Cen[i] is low.
- Pause_ack  output  1  high while frozen in PAUSED.

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - Cen=all 1, Fall_strobe=0, Pause_ack=0, state=RUN.
  - Each counter loads min(Phase_i, Div_i).
  - Reset mid-operation (any state) gives the same values at the next edge.
- Channel counting (channel active, not frozen):
  - If cnt_i >= Div_i: cnt_i<=0 and Cen[i] toggles. Otherwise cnt_i<=cnt_i+1.
  - Period = 2*(Div_i+1) Clk cycles, duty 50%.
  - Div_i=0 toggles every cycle (period 2).
- Div change mid-run takes effect at the next compare. The >= compare gives a wrap on the next cycle when cnt_i exceeds the new Div.
- Enable[i]=0: Cen[i] forced to 1 next cycle; cnt_i <= min(Phase_i, Div_i).
- Re-enable: counting resumes from the preload with Cen[i]=1.
- Fall_strobe[i]=1 exactly in the cycle where Cen[i] is 0 and was 1 in the previous cycle. Registered alongside Cen; never asserted on reset release.
- State machine (states RUN, DRAIN, PAUSED, STEP):
  - RUN: all active channels count. Pause_req=1 -> DRAIN.
  - DRAIN:
    - A channel with Cen=1 freezes (counter and Cen hold).
    - A channel with Cen=0 keeps counting until it toggles high, then freezes.
    - When all Cen=1 -> PAUSED. This includes the same cycle in which the last channel rises, so PAUSED is entered the following edge.
    - Pause_req=0 in DRAIN -> RUN; frozen channels resume from their held counts.
  - PAUSED:
    - Pause_ack=1; all counters and Cen hold.
    - Pause_req=0 -> RUN, with Pause_ack=0 at the same edge.
    - Else Step_req=1 -> STEP, with Pause_ack=0.
    - Simultaneous Pause_req=0 and Step_req=1: resume wins; step is dropped.
  - STEP:
    - All active channels count.
    - When Cen[0] has fallen and then risen again -> DRAIN, which leads back to PAUSED.
    - If channel 0 is disabled, STEP goes directly to DRAIN.
    - Step_req pulses outside PAUSED are ignored (no queueing).
- Pause_ack deasserts in any state other than PAUSED.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, CHANNELS=4, Div={3,1,0,7}, Phase=0, Enable=4'hF -> Cen[0] period 8 (4 high, 4 low), Cen[1] period 4, Cen[2] period 2, Cen[3] period 16; Fall_strobe is a one-cycle pulse at each falling edge.
- Div0=3, Phase0=2 vs Phase1=0, Div1=3 -> Cen[0] first toggles 2 cycles before Cen[1]; fixed 2-cycle skew persists.
- Pause_req asserted while Cen[0]=0 with cnt0=1, Div0=3 -> channel 0 counts 2 more cycles, rises; Pause_ack=1 on the following edge; all Cen=1 and frozen for 100 cycles.
- In PAUSED, pulse Step_req with Div0=3 -> exactly one Fall_strobe[0] and Cen[0] low for 4 cycles; returns to PAUSED with Pause_ack=1; no further Cen[0] edges.
- In DRAIN, drop Pause_req -> RUN next cycle; frozen channels resume without missing or extra toggles. In PAUSED, drop Pause_req and pulse Step_req together -> RUN, no step.
- Assert Reset_n=0 during STEP -> next edge Cen=4'hF, Pause_ack=0, state RUN; Enable[2]=0 mid-run -> Cen[2]=1 next cycle and held.
